dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Control front-end for the DDS waveform generator. Turns debounced single-cycle key pulses into a registered 12-bit frequency tuning word `KW` and a one-hot waveform select for the DDS phase-accumulator/ROM block. It supports manual frequency stepping, waveform cycling and an automatic triangular frequency sweep. It sits between the key-debounce modules and the DDS core, and drives that core's `KW` and `SW_*_In` inputs directly.

## Interface
- `KW_MIN`, 1, lower bound of the tuning word; the reset value of `KW`. Must satisfy 1 ≤ KW_MIN < KW_MAX.
- `KW_MAX`, 512, upper bound of the tuning word; ≤ 4095.
- `STEP`, 8, tuning-word increment per manual key press or sweep step; 1 ≤ STEP ≤ KW_MAX−KW_MIN.
- `DWELL`, 50000, clock cycles spent at each sweep step; ≥ 2. The counter is 17 bits wide.
- `CLK` in 1: system clock; all logic on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `Key_Wave_In` in 1: single-cycle pulse; advances the waveform select.
- `Key_Up_In` in 1: single-cycle pulse; raises `KW` by STEP (manual mode only).
- `Key_Down_In` in 1: single-cycle pulse; lowers `KW` by STEP (manual mode only).
- `Key_Sweep_In` in 1: single-cycle pulse; toggles between manual and sweep modes.
- `KW` out 12: tuning word to the DDS.
- `SW_Sin_Out`, `SW_Square_Out`, `SW_Sawtooth_Out` out 1 each: one-hot waveform select.
- `Sweep_Busy` out 1: high while in a sweep state.

## Operation
- **FSM states:**
  - `MANUAL`: reset state.
  - `SWEEP_UP`
  - `SWEEP_DOWN`
- **Reset values:**
  - `KW`=KW_MIN.
  - Sin selected (100).
  - `Sweep_Busy`=0.
  - Dwell counter=0.
  - State=`MANUAL`.
- **Waveform select:** each `Key_Wave_In` pulse rotates the select Sin → Square → Sawtooth → Sin. This works in every state. Exactly one select output is high at all times.
- **MANUAL, `Key_Up_In`:** `KW` ← min(KW+STEP, KW_MAX).
- **MANUAL, `Key_Down_In`:** `KW` ← max(KW−STEP, KW_MIN).
- **MANUAL, Up and Down in the same cycle:** no change.
- **Width rules:** sums and differences are computed 13 bits wide, so there is no wrap-around; results saturate at the bounds.
- **`Key_Sweep_In` in MANUAL:**
  - The dwell counter is cleared.
  - Next state is `SWEEP_DOWN` if KW == KW_MAX, else `SWEEP_UP`.
  - The sweep key takes precedence: Up/Down pulses in that same cycle are ignored.
- **`Key_Sweep_In` in either sweep state:**
  - Go to `MANUAL`.
  - `KW` holds its current value.
  - The dwell counter is cleared.
- **Up/Down pulses in sweep states:** ignored.
- **Dwell counter:** counts 0..DWELL−1 while in a sweep state. When it reaches DWELL−1 it wraps to 0 and a step is taken.
- **Step in `SWEEP_UP`:** KW ← min(KW+STEP, KW_MAX). If the result equals KW_MAX, the next state is `SWEEP_DOWN`.
- **Step in `SWEEP_DOWN`:** KW ← max(KW−STEP, KW_MIN). If the result equals KW_MIN, the next state is `SWEEP_UP`.
- **Sweep key coinciding with a step:** the sweep key wins; no step is taken and the FSM goes to `MANUAL`.
- **Sweep key and wave key in the same cycle:** both act.
- **Reset asserted mid-operation:** all registers return to their reset values immediately. The first key is accepted on the first rising edge after `RST` deasserts.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- **Key latency:** a key pulse sampled at edge n produces its output change at edge n (the value is visible during cycle n+1).
- **Sweep step timing:**
  - The first step occurs DWELL edges after the edge that accepted `Key_Sweep_In`.
  - Subsequent steps occur every DWELL edges.
  - `KW` therefore changes only on step edges.
- `Sweep_Busy` rises and falls on the same edge as the state change.
- **Full triangle period:** 2·⌈(KW_MAX−KW_MIN)/STEP⌉·DWELL cycles. The final step toward a bound is truncated by saturation.

## Test plan
Parameters for the bench: KW_MIN=1, KW_MAX=33, STEP=8, DWELL=4.
1. **Reset:** assert `RST` asynchronously mid-cycle → `KW`=1, selects=100, `Sweep_Busy`=0, with no clock edge needed.
2. **Waveform cycling:** three `Key_Wave_In` pulses → selects 010, 001, 100, each one cycle after its pulse.
3. **Manual stepping and saturation:**
   - Five `Key_Up_In` pulses → `KW` 9, 17, 25, 33, 33.
   - Then Up and Down in the same cycle → `KW` stays 33.
   - Then six `Key_Down_In` pulses → `KW` 25, 17, 9, 1, 1, 1.
4. **Triangle sweep:** from `KW`=1, pulse `Key_Sweep_In` → `Sweep_Busy`=1. `KW` then moves every 4 cycles through 9, 17, 25, 33 (`SWEEP_DOWN` entered), then 25, 17, 9, 1 (`SWEEP_UP` entered), then 9.
5. **Sweep exit and ignored keys:**
   - While sweeping, `Key_Up_In` → no effect.
   - `Key_Sweep_In` on a step edge → no step, `KW` held, `Sweep_Busy`=0.
   - A following `Key_Up_In` → `KW`+8, saturating at 33.
6. **Edge entry and mid-sweep reset:**
   - From `KW`=33, `Key_Sweep_In` → first step goes to 25 (sweep starts downward).
   - Assert `RST` mid-sweep → `KW`=1, state `MANUAL`.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: key-driven DDS tuning word and waveform select with a triangular auto-sweep
module dds_sweep_ctrl #(
  parameter int KW_MIN = 1,
  parameter int KW_MAX = 512,
  parameter int STEP   = 8,
  parameter int DWELL  = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Key_Wave_In,
  input  logic        Key_Up_In,
  input  logic        Key_Down_In,
  input  logic        Key_Sweep_In,
  output logic [11:0] KW,
  output logic        SW_Sin_Out,
  output logic        SW_Square_Out,
  output logic        SW_Sawtooth_Out,
  output logic        Sweep_Busy
);
  typedef enum logic [1:0] {MANUAL, SWEEP_UP, SWEEP_DOWN} state_t;
  localparam logic [11:0] MIN12 = 12'(KW_MIN);
  localparam logic [11:0] MAX12 = 12'(KW_MAX);
  localparam logic [12:0] STEP13 = 13'(STEP);
  localparam logic [16:0] LAST = 17'(DWELL - 1);
  state_t state_q, state_d;
  logic [11:0] kw_q, kw_d, up_sat, dn_sat;
  logic [2:0] sel_q, sel_d;
  logic [16:0] cnt_q, cnt_d;
  logic [12:0] up_sum, dn_dif;
  // 13-bit arithmetic so neither bound can wrap before saturation
  assign up_sum = {1'b0, kw_q} + STEP13;
  assign dn_dif = {1'b0, kw_q} - STEP13;
  assign up_sat = up_sum > {1'b0, MAX12} ? MAX12 : up_sum[11:0];
  assign dn_sat = {1'b0, kw_q} < {1'b0, MIN12} + STEP13 ? MIN12 : dn_dif[11:0];
  always_comb begin
    state_d = state_q;
    kw_d = kw_q;
    cnt_d = cnt_q;
    sel_d = Key_Wave_In ? {sel_q[0], sel_q[2:1]} : sel_q;
    if (state_q == MANUAL) begin
      if (Key_Sweep_In) begin
        cnt_d = '0;
        state_d = kw_q == MAX12 ? SWEEP_DOWN : SWEEP_UP;
      end else if (Key_Up_In ^ Key_Down_In) kw_d = Key_Up_In ? up_sat : dn_sat;
    end else if (Key_Sweep_In) begin
      state_d = MANUAL;
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      kw_d = state_q == SWEEP_UP ? up_sat : dn_sat;
      if (state_q == SWEEP_UP && up_sat == MAX12) state_d = SWEEP_DOWN;
      else if (state_q == SWEEP_DOWN && dn_sat == MIN12) state_d = SWEEP_UP;
    end else cnt_d = cnt_q + 17'd1;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= MANUAL;
      kw_q <= MIN12;
      sel_q <= 3'b100;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      kw_q <= kw_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end
  assign KW = kw_q;
  assign {SW_Sin_Out, SW_Square_Out, SW_Sawtooth_Out} = sel_q;
  assign Sweep_Busy = state_q != MANUAL;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: scoreboard bench for the sweep controller with small bounds
module tb_dds_sweep_ctrl;
  logic clk = 0, rst = 1;
  logic wave = 0, up = 0, dn = 0, sw = 0;
  logic [11:0] kw;
  logic s_sin, s_sq, s_saw, busy;
  int checks = 0, errors = 0;
  logic [15:0] sb[$];
  dds_sweep_ctrl #(.KW_MIN(1), .KW_MAX(33), .STEP(8), .DWELL(4)) dut (
    .CLK(clk), .RST(rst), .Key_Wave_In(wave), .Key_Up_In(up), .Key_Down_In(dn),
    .Key_Sweep_In(sw), .KW(kw), .SW_Sin_Out(s_sin), .SW_Square_Out(s_sq),
    .SW_Sawtooth_Out(s_saw), .Sweep_Busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic compare(input string tag);
    logic [15:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_kw"}, 32'(kw), 32'(e[15:4]));
    check({tag, "_sel"}, 32'({s_sin, s_sq, s_saw}), 32'(e[3:1]));
    check({tag, "_busy"}, 32'(busy), 32'(e[0]));
  endtask
  task automatic cyc(input string tag, input logic w, u, d, s, input logic [11:0] ekw, input logic [2:0] esel, input logic eb);
    @(negedge clk);
    {wave, up, dn, sw} = {w, u, d, s};
    sb.push_back({ekw, esel, eb});
    @(posedge clk);
    #1 {wave, up, dn, sw} = 4'b0;
    compare(tag);
  endtask
  task automatic rst_mid(input string tag, input logic [11:0] ekw, input logic [2:0] esel);
    @(posedge clk);
    #3 rst = 1;
    sb.push_back({ekw, esel, 1'b0});
    #1 compare(tag);
    @(negedge clk) rst = 0;
  endtask
  initial begin
    logic [11:0] prev;
    int steps[9] = '{9, 17, 25, 33, 25, 17, 9, 1, 9};
    int ups[5] = '{9, 17, 25, 33, 33};
    int dns[6] = '{25, 17, 9, 1, 1, 1};
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    cyc("pre_up", 0, 1, 0, 0, 9, 3'b100, 0);
    rst_mid("reset", 1, 3'b100);
    cyc("wave1", 1, 0, 0, 0, 1, 3'b010, 0);
    cyc("wave2", 1, 0, 0, 0, 1, 3'b001, 0);
    cyc("wave3", 1, 0, 0, 0, 1, 3'b100, 0);
    foreach (ups[i]) cyc("up", 0, 1, 0, 0, 12'(ups[i]), 3'b100, 0);
    cyc("updn", 0, 1, 1, 0, 33, 3'b100, 0);
    foreach (dns[i]) cyc("down", 0, 0, 1, 0, 12'(dns[i]), 3'b100, 0);
    cyc("sweep_on", 0, 0, 0, 1, 1, 3'b100, 1);
    prev = 1;
    foreach (steps[i]) begin
      repeat (3) cyc("dwell", 0, 0, 0, 0, prev, 3'b100, 1);
      prev = 12'(steps[i]);
      cyc("step", 0, 0, 0, 0, prev, 3'b100, 1);
    end
    cyc("sweep_up_ign", 0, 1, 0, 0, 9, 3'b100, 1);
    repeat (2) cyc("dwell2", 0, 0, 0, 0, 9, 3'b100, 1);
    cyc("sweep_off", 0, 0, 0, 1, 9, 3'b100, 0);
    cyc("man_up", 0, 1, 0, 0, 17, 3'b100, 0);
    cyc("man_up", 0, 1, 0, 0, 25, 3'b100, 0);
    cyc("man_up", 0, 1, 0, 0, 33, 3'b100, 0);
    cyc("man_sat", 0, 1, 0, 0, 33, 3'b100, 0);
    cyc("edge_entry", 1, 0, 0, 1, 33, 3'b010, 1);
    repeat (3) cyc("edge_dwell", 0, 0, 0, 0, 33, 3'b010, 1);
    cyc("edge_step", 0, 0, 0, 0, 25, 3'b010, 1);
    cyc("edge_hold", 0, 0, 0, 0, 25, 3'b010, 1);
    rst_mid("reset_sweep", 1, 3'b100);
    cyc("post_rst", 1, 1, 0, 0, 9, 3'b010, 0);
    cyc("post_rst_idle", 0, 0, 0, 0, 9, 3'b010, 0);
    check("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
